// File: rtl/mxu_skew_feeder_pkg.sv
// Shared feed-path definitions: FSM encodings for the skew feeder and RAM buffer,
// plus default lane geometry.
package mxu_skew_feeder_pkg;

  localparam int LANE_NUM_DEF   = 16;
  localparam int LANE_WIDTH_DEF = 8;
  localparam int ROW_CNT_W      = 4;
  localparam int DRAIN_CNT_W    = 5;

  typedef enum logic [1:0] {
    SKEW_FSM_IDLE  = 2'd0,
    SKEW_FSM_FEED  = 2'd1,
    SKEW_FSM_DRAIN = 2'd2
  } skew_fsm_e;

  typedef enum logic [1:0] {
    RAM_BUFF_FSM_IDLE = 2'd0,
    RAM_BUFF_FSM_LOAD = 2'd1,
    RAM_BUFF_FSM_READ = 2'd2
  } ram_buff_fsm_e;

endpackage

// File: rtl/skew_lane_delay.sv
// One lane of the skew wavefront: DEPTH stall-held valid+data stages.
// Latency DEPTH shifts; every stage freezes while shift_en is low.
module skew_lane_delay #(
  parameter int DEPTH      = 1,
  parameter int LANE_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  shift_en,
  input  logic                  head_vld,
  input  logic [LANE_WIDTH-1:0] head_data,
  output logic                  tail_vld,
  output logic [LANE_WIDTH-1:0] tail_data
);

  logic [DEPTH-1:0]      vld_q;
  logic [LANE_WIDTH-1:0] data_q [DEPTH];

  // rst_n is an active-high synchronous reset
  always_ff @(posedge clk) begin
    if (rst_n) begin
      vld_q <= '0;
      for (int k = 0; k < DEPTH; k++) data_q[k] <= '0;
    end else if (shift_en) begin
      vld_q[0]  <= head_vld;
      data_q[0] <= head_data;
      for (int k = 1; k < DEPTH; k++) begin
        vld_q[k]  <= vld_q[k-1];
        data_q[k] <= data_q[k-1];
      end
    end
  end

  assign tail_vld  = vld_q[DEPTH-1];
  assign tail_data = data_q[DEPTH-1];

endmodule

// File: rtl/mxu_skew_feeder.sv
// Feeds row blocks into the MXU edge as a diagonal wavefront (lane i delayed i+1 cycles).
// Latency lane i = i+1 unstalled cycles; mxu_stall freezes every stage and drops skew_rdy.
module mxu_skew_feeder
  import mxu_skew_feeder_pkg::*;
#(
  parameter int LANE_NUM   = LANE_NUM_DEF,
  parameter int LANE_WIDTH = LANE_WIDTH_DEF
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             ctrl_skew_vld,
  input  logic [ROW_CNT_W-1:0]             ctrl_skew_row_num,
  input  logic [LANE_NUM-1:0]              ram_buff_mxu_vld,
  input  logic [LANE_NUM*LANE_WIDTH-1:0]   ram_buff_mxu_data,
  input  logic                             mxu_stall,
  output logic                             skew_rdy,
  output logic [LANE_NUM-1:0]              skew_mxu_vld,
  output logic [LANE_NUM*LANE_WIDTH-1:0]   skew_mxu_data,
  output logic                             skew_done,
  output logic                             skew_err
);

  localparam logic [DRAIN_CNT_W-1:0] DRAIN_LAST = DRAIN_CNT_W'(LANE_NUM - 1);

  skew_fsm_e              state, state_nxt;
  logic [ROW_CNT_W-1:0]   row_cnt, row_cnt_nxt;
  logic [ROW_CNT_W-1:0]   row_num, row_num_nxt;
  logic [DRAIN_CNT_W-1:0] drain_cnt, drain_cnt_nxt;
  logic                   err_nxt;
  logic                   accept;
  logic                   row_present;
  logic [LANE_NUM-1:0]    head_vld;

  assign skew_rdy    = (state == SKEW_FSM_FEED) && !mxu_stall;
  assign row_present = |ram_buff_mxu_vld;
  assign accept      = skew_rdy && row_present;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state     <= SKEW_FSM_IDLE;
      row_cnt   <= '0;
      row_num   <= '0;
      drain_cnt <= '0;
      skew_err  <= 1'b0;
    end else begin
      state     <= state_nxt;
      row_cnt   <= row_cnt_nxt;
      row_num   <= row_num_nxt;
      drain_cnt <= drain_cnt_nxt;
      skew_err  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    row_cnt_nxt   = row_cnt;
    row_num_nxt   = row_num;
    drain_cnt_nxt = drain_cnt;
    skew_done     = 1'b0;
    case (state)
      SKEW_FSM_IDLE: begin
        if (ctrl_skew_vld) begin
          state_nxt   = SKEW_FSM_FEED;
          row_num_nxt = ctrl_skew_row_num;
          row_cnt_nxt = '0;
        end
      end
      SKEW_FSM_FEED: begin
        if (accept) begin
          row_cnt_nxt = row_cnt + 4'd1;
          if (row_cnt == row_num) begin
            state_nxt     = SKEW_FSM_DRAIN;
            drain_cnt_nxt = '0;
          end
        end
      end
      SKEW_FSM_DRAIN: begin
        // The unstalled cycle that would take the count to LANE_NUM is the one in
        // which the last row's lane LANE_NUM-1 leaves its final stage.
        if (!mxu_stall) begin
          if (drain_cnt == DRAIN_LAST) begin
            state_nxt     = SKEW_FSM_IDLE;
            drain_cnt_nxt = '0;
            skew_done     = 1'b1;
          end else begin
            drain_cnt_nxt = drain_cnt + 5'd1;
          end
        end
      end
      default: state_nxt = SKEW_FSM_IDLE;
    endcase
  end

  // Restart attempts outside IDLE and rows offered while not ready are both dropped.
  assign err_nxt = skew_err
                 || (ctrl_skew_vld && (state != SKEW_FSM_IDLE))
                 || (row_present && !skew_rdy);

  for (genvar i = 0; i < LANE_NUM; i++) begin : g_lane
    logic [LANE_WIDTH-1:0] head_data;

    assign head_vld[i] = accept && ram_buff_mxu_vld[i];
    assign head_data   = head_vld[i] ? ram_buff_mxu_data[i*LANE_WIDTH +: LANE_WIDTH] : '0;

    skew_lane_delay #(
      .DEPTH      (i + 1),
      .LANE_WIDTH (LANE_WIDTH)
    ) u_delay (
      .clk       (clk),
      .rst_n     (rst_n),
      .shift_en  (!mxu_stall),
      .head_vld  (head_vld[i]),
      .head_data (head_data),
      .tail_vld  (skew_mxu_vld[i]),
      .tail_data (skew_mxu_data[i*LANE_WIDTH +: LANE_WIDTH])
    );
  end

endmodule

// File: tb/tb_mxu_skew_feeder.sv
// Directed bench for mxu_skew_feeder: hand-timed ready/done/error vectors plus a
// delay-line reference for the skewed lane outputs.
module tb_mxu_skew_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         ctrl_skew_vld;
  logic [3:0]   ctrl_skew_row_num;
  logic [15:0]  ram_buff_mxu_vld;
  logic [127:0] ram_buff_mxu_data;
  logic         mxu_stall;
  logic         skew_rdy;
  logic [15:0]  skew_mxu_vld;
  logic [127:0] skew_mxu_data;
  logic         skew_done;
  logic         skew_err;

  int n_vec = 0;
  int n_err = 0;
  int cyc_no = 0;
  int sc = 0;
  logic [15:0]  m_vld [512];
  logic [127:0] m_dat [512];

  localparam logic [127:0] R0   = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] R1   = 128'h1F1E1D1C1B1A19181716151413121110;
  localparam logic [127:0] R2   = 128'h2F2E2D2C2B2A29282726252423222120;
  localparam logic [127:0] R3   = 128'h3F3E3D3C3B3A39383736353433323130;
  localparam logic [127:0] ONES = {128{1'b1}};

  always #5 clk = ~clk;

  mxu_skew_feeder dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .ctrl_skew_vld     (ctrl_skew_vld),
    .ctrl_skew_row_num (ctrl_skew_row_num),
    .ram_buff_mxu_vld  (ram_buff_mxu_vld),
    .ram_buff_mxu_data (ram_buff_mxu_data),
    .mxu_stall         (mxu_stall),
    .skew_rdy          (skew_rdy),
    .skew_mxu_vld      (skew_mxu_vld),
    .skew_mxu_data     (skew_mxu_data),
    .skew_done         (skew_done),
    .skew_err          (skew_err)
  );

  function automatic logic [127:0] lane_mask(input logic [15:0] v);
    logic [127:0] m;
    m = '0;
    for (int i = 0; i < 16; i++) m[8*i +: 8] = {8{v[i]}};
    return m;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL c%0d %s observed=%h expected=%h", cyc_no, tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int j = 0; j < 512; j++) begin
      m_vld[j] = '0;
      m_dat[j] = '0;
    end
  endtask

  // One clock: drive inputs, check at the falling edge, then advance the reference.
  task automatic cyc(input logic rst, input logic ctrl, input logic [3:0] rn,
                     input logic [15:0] vld, input logic [127:0] dat, input logic stall,
                     input logic acc, input logic e_rdy, input logic e_done, input logic e_err);
    logic [15:0]  ev;
    logic [127:0] ed;
    rst_n = rst;
    ctrl_skew_vld = ctrl;
    ctrl_skew_row_num = rn;
    ram_buff_mxu_vld = vld;
    ram_buff_mxu_data = dat;
    mxu_stall = stall;
    @(negedge clk);
    ev = '0;
    ed = '0;
    for (int i = 0; i < 16; i++) begin
      int idx;
      idx = sc - 1 - i;
      if (idx >= 0) begin
        ev[i] = m_vld[idx][i];
        ed[8*i +: 8] = m_dat[idx][8*i +: 8];
      end
    end
    chk("skew_rdy", 128'(skew_rdy), 128'(e_rdy));
    chk("skew_done", 128'(skew_done), 128'(e_done));
    chk("skew_err", 128'(skew_err), 128'(e_err));
    chk("skew_mxu_vld", 128'(skew_mxu_vld), 128'(ev));
    chk("skew_mxu_data", skew_mxu_data, ed);
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else if (!stall) begin
      m_vld[sc] = acc ? vld : 16'h0;
      m_dat[sc] = acc ? (dat & lane_mask(vld)) : '0;
      sc++;
    end
    cyc_no++;
    #1;
  endtask

  task automatic idle(input int n, input logic e_err);
    for (int k = 0; k < n; k++) cyc(0, 0, 4'd0, 16'h0, '0, 0, 0, 0, 0, e_err);
  endtask

  task automatic stall_cyc(input int n, input logic e_rdy_dummy, input logic e_err);
    for (int k = 0; k < n; k++) cyc(0, 0, 4'd0, 16'h0, '0, 1, 0, e_rdy_dummy, 0, e_err);
  endtask

  task automatic start(input logic [3:0] rn, input logic e_err);
    cyc(0, 1, rn, 16'h0, '0, 0, 0, 0, 0, e_err);
  endtask

  task automatic row(input logic [15:0] vld, input logic [127:0] dat, input logic e_err);
    cyc(0, 0, 4'd0, vld, dat, 0, 1, 1, 0, e_err);
  endtask

  // Last row accepted in the previous cycle: done lands 16 cycles after that accept.
  task automatic drain(input logic e_err);
    idle(15, e_err);
    cyc(0, 0, 4'd0, 16'h0, '0, 0, 0, 0, 1, e_err);
    idle(1, e_err);
  endtask

  initial begin
    model_clear();
    rst_n = 1'b1;
    ctrl_skew_vld = 1'b0;
    ctrl_skew_row_num = '0;
    ram_buff_mxu_vld = '0;
    ram_buff_mxu_data = '0;
    mxu_stall = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Reset state
    idle(2, 0);

    // Single row, all lanes valid
    start(4'd0, 0);
    row(16'hFFFF, R0, 0);
    drain(0);

    // Four back-to-back rows
    start(4'd3, 0);
    row(16'hFFFF, R0, 0);
    row(16'hFFFF, R1, 0);
    row(16'hFFFF, R2, 0);
    row(16'hFFFF, R3, 0);
    drain(0);

    // Stall for 3 cycles mid-feed, then 2 cycles mid-drain
    start(4'd3, 0);
    row(16'hFFFF, R0, 0);
    row(16'hFFFF, R1, 0);
    stall_cyc(3, 0, 0);
    row(16'hFFFF, R2, 0);
    row(16'hFFFF, R3, 0);
    idle(5, 0);
    stall_cyc(2, 0, 0);
    idle(10, 0);
    cyc(0, 0, 4'd0, 16'h0, '0, 0, 0, 0, 1, 0);
    idle(1, 0);

    // Row, bubble, partial-valid row with two-row block
    start(4'd1, 0);
    row(16'hFFFF, R1, 0);
    cyc(0, 0, 4'd0, 16'h0, '0, 0, 0, 1, 0, 0);
    row(16'h00FF, ONES, 0);
    drain(0);

    // Restart request during drain: flagged, transfer unaffected
    start(4'd0, 0);
    row(16'hFFFF, R2, 0);
    cyc(0, 1, 4'd5, 16'h0, '0, 0, 0, 0, 0, 0);
    idle(14, 1);
    cyc(0, 0, 4'd0, 16'h0, '0, 0, 0, 0, 1, 1);
    idle(2, 1);

    // Reset clears the flag; a row offered in IDLE is dropped and flagged
    cyc(1, 0, 4'd0, 16'h0, '0, 0, 0, 0, 0, 1);
    idle(1, 0);
    cyc(0, 0, 4'd0, 16'h0001, R3, 0, 0, 0, 0, 0);
    idle(3, 1);

    // Reset in the fifth cycle of a 16-row feed
    cyc(1, 0, 4'd0, 16'h0, '0, 0, 0, 0, 0, 1);
    idle(1, 0);
    start(4'd15, 0);
    row(16'hFFFF, R0, 0);
    row(16'hFFFF, R1, 0);
    row(16'hFFFF, R2, 0);
    row(16'hFFFF, R3, 0);
    cyc(1, 0, 4'd0, 16'h0, '0, 0, 0, 1, 0, 0);
    idle(20, 0);
    start(4'd0, 0);
    row(16'hFFFF, R3, 0);
    drain(0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
